// File: rtl/cram_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cram_access_arbiter_pkg
// Shared types and constants for the CRAM bank arbiter: the arbiter FSM state
// encoding, datapath mux select values and the round-robin pick helper.
// -----------------------------------------------------------------------------
package cram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    iDLE_ARB     = 2'd0,
    gRANT_LD_ARB = 2'd1,
    gRANT_ST_ARB = 2'd2,
    dRAIN_ARB    = 2'd3
  } fsm_cram_arb;

  localparam logic SEL_LD = 1'b0;
  localparam logic SEL_ST = 1'b1;

  // Store wins when it is the only candidate, or when both contend and the
  // load side was served last.
  function automatic logic rr_pick_st(input logic cand_ld,
                                      input logic cand_st,
                                      input logic last);
    return cand_st & (~cand_ld | (last == SEL_LD));
  endfunction

endpackage

// File: rtl/cram_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// cram_access_arbiter_if
// Handshake bundle between the load/store sequence controllers, the CRAM bank
// and the arbiter.
//   I_Ld_* / I_St_* : Acq (start pulse), Req (per-word), Rls (release),
//                     Trm (termination) from each controller
//   O_*_Grant       : ownership indication per side
//   O_*_Nack        : stall per side
//   O_Mem_Req/We    : forwarded request / write enable to the bank
//   O_Sel           : datapath select (0 = load, 1 = store)
//   O_Busy          : bank owned or draining
//   O_Timeout       : one-cycle pulse on watchdog-forced release
// modport master : controller/bank side; modport slave : arbiter side.
// -----------------------------------------------------------------------------
interface cram_access_arbiter_if;

  logic I_Ld_Acq;
  logic I_Ld_Req;
  logic I_Ld_Rls;
  logic I_Ld_Trm;
  logic I_St_Acq;
  logic I_St_Req;
  logic I_St_Rls;
  logic I_St_Trm;
  logic O_Ld_Grant;
  logic O_St_Grant;
  logic O_Ld_Nack;
  logic O_St_Nack;
  logic O_Mem_Req;
  logic O_Mem_We;
  logic O_Sel;
  logic O_Busy;
  logic O_Timeout;

  modport master (
    output I_Ld_Acq, I_Ld_Req, I_Ld_Rls, I_Ld_Trm,
    output I_St_Acq, I_St_Req, I_St_Rls, I_St_Trm,
    input  O_Ld_Grant, O_St_Grant, O_Ld_Nack, O_St_Nack,
    input  O_Mem_Req, O_Mem_We, O_Sel, O_Busy, O_Timeout
  );

  modport slave (
    input  I_Ld_Acq, I_Ld_Req, I_Ld_Rls, I_Ld_Trm,
    input  I_St_Acq, I_St_Req, I_St_Rls, I_St_Trm,
    output O_Ld_Grant, O_St_Grant, O_Ld_Nack, O_St_Nack,
    output O_Mem_Req, O_Mem_We, O_Sel, O_Busy, O_Timeout
  );

endinterface

// File: rtl/cram_access_arbiter.sv
// -----------------------------------------------------------------------------
// cram_access_arbiter
// Arbitrates a single-ported CRAM bank between the load- and store-sequence
// controllers. Ownership lasts a whole sequence (Acq .. Rls/Trm), is granted
// round-robin, and is followed by a drain window covering RAM read latency.
// An idle watchdog forces release if the owner stops issuing Req.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : cram_access_arbiter_if.slave (controller inputs, bank/status outputs)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// iDLE_ARB   | bank free, arbitrate pending flags and same-cycle Acq
// gRANT_LD_ARB | load controller owns the bank, its Req is forwarded
// gRANT_ST_ARB | store controller owns the bank, its Req is forwarded
// dRAIN_ARB  | post-release window, no requests reach the bank
// -----------------------------------------------------------------------------
module cram_access_arbiter
  import cram_access_arbiter_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int MAX_IDLE     = 64,
  parameter int WIDTH_IDLE   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  cram_access_arbiter_if.slave  bus
);

  localparam logic [3:0] DRAIN_LOAD = 4'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [WIDTH_IDLE-1:0] IDLE_LIMIT =
    WIDTH_IDLE'((MAX_IDLE > 0) ? MAX_IDLE - 1 : 0);

  fsm_cram_arb           state_q, state_d;
  logic                  pend_ld_q, pend_ld_d;
  logic                  pend_st_q, pend_st_d;
  logic                  last_q, last_d;
  logic [3:0]            drain_q, drain_d;
  logic [WIDTH_IDLE-1:0] idle_q, idle_d;
  logic                  timeout_q, timeout_d;

  logic cand_ld, cand_st;
  logic own_req, own_rel, wd_hit;
  logic grant_ld, grant_st;

  assign grant_ld = (state_q == gRANT_LD_ARB);
  assign grant_st = (state_q == gRANT_ST_ARB);

  always_comb begin
    state_d   = state_q;
    // An Acq from the side that already owns the bank is dropped.
    pend_ld_d = pend_ld_q | (bus.I_Ld_Acq & ~grant_ld);
    pend_st_d = pend_st_q | (bus.I_St_Acq & ~grant_st);
    last_d    = last_q;
    drain_d   = drain_q;
    idle_d    = idle_q;
    timeout_d = 1'b0;
    cand_ld   = pend_ld_q | bus.I_Ld_Acq;
    cand_st   = pend_st_q | bus.I_St_Acq;
    own_req   = grant_st ? bus.I_St_Req : bus.I_Ld_Req;
    own_rel   = grant_st ? (bus.I_St_Rls | bus.I_St_Trm)
                         : (bus.I_Ld_Rls | bus.I_Ld_Trm);
    wd_hit    = 1'b0;

    case (state_q)
      iDLE_ARB: begin
        if (cand_ld | cand_st) begin
          idle_d = '0;
          if (rr_pick_st(cand_ld, cand_st, last_q)) begin
            state_d   = gRANT_ST_ARB;
            pend_st_d = 1'b0;
            last_d    = SEL_ST;
          end else begin
            state_d   = gRANT_LD_ARB;
            pend_ld_d = 1'b0;
            last_d    = SEL_LD;
          end
        end
      end

      gRANT_LD_ARB, gRANT_ST_ARB: begin
        wd_hit = (MAX_IDLE != 0) && !own_req && (idle_q == IDLE_LIMIT);
        idle_d = own_req ? '0 : idle_q + 1'b1;
        if (own_rel | wd_hit) begin
          state_d   = (DRAIN_CYCLES == 0) ? iDLE_ARB : dRAIN_ARB;
          drain_d   = DRAIN_LOAD;
          idle_d    = '0;
          timeout_d = wd_hit;
        end
      end

      dRAIN_ARB: begin
        if (drain_q == 4'd0) begin
          state_d = iDLE_ARB;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      default: state_d = iDLE_ARB;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= iDLE_ARB;
      pend_ld_q <= 1'b0;
      pend_st_q <= 1'b0;
      last_q    <= SEL_LD;
      drain_q   <= 4'd0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_ld_q <= pend_ld_d;
      pend_st_q <= pend_st_d;
      last_q    <= last_d;
      drain_q   <= drain_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.O_Ld_Grant = grant_ld;
  assign bus.O_St_Grant = grant_st;
  assign bus.O_Ld_Nack  = (pend_ld_q | bus.I_Ld_Acq | bus.I_Ld_Req) & ~grant_ld;
  assign bus.O_St_Nack  = (pend_st_q | bus.I_St_Acq | bus.I_St_Req) & ~grant_st;
  assign bus.O_Mem_Req  = (grant_ld & bus.I_Ld_Req) | (grant_st & bus.I_St_Req);
  assign bus.O_Mem_We   = grant_st & bus.I_St_Req;
  // last_q is updated only on a grant, so it is the select of the current or
  // most recent owner and naturally holds through DRAIN and IDLE.
  assign bus.O_Sel      = last_q;
  assign bus.O_Busy     = (state_q != iDLE_ARB);
  assign bus.O_Timeout  = timeout_q;

endmodule

// File: tb/tb_cram_access_arbiter.sv
module tb_cram_access_arbiter;

  localparam int DRAIN    = 2;
  localparam int MAX_IDLE = 64;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] ACQ  = 4'b0001;
  localparam logic [3:0] REQ  = 4'b0010;
  localparam logic [3:0] RLS  = 4'b0100;
  localparam logic [3:0] TRM  = 4'b1000;

  logic clk;
  logic rst_n;

  cram_access_arbiter_if arb_if();

  cram_access_arbiter #(
    .DRAIN_CYCLES (DRAIN),
    .MAX_IDLE     (MAX_IDLE),
    .WIDTH_IDLE   (8)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int to_seen = 0;

  // expected output vector:
  // {ld_grant, st_grant, ld_nack, st_nack, mem_req, mem_we, sel, busy, timeout}
  logic [8:0] exp_q[$];

  // Reference model: who owns the bank, how many drain cycles remain,
  // outstanding sequence starts, who was served last, idle run length.
  int   m_owner;     // 0 none, 1 load, 2 store
  int   m_drain;
  logic m_pend_ld, m_pend_st;
  logic m_last;      // 0 load served last, 1 store
  int   m_idle;
  logic m_to;

  task automatic model_reset();
    m_owner = 0; m_drain = 0; m_pend_ld = 0; m_pend_st = 0;
    m_last = 0; m_idle = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [3:0] ld, input logic [3:0] st,
                            output logic [8:0] e);
    logic ld_acq, ld_req, ld_rel, st_acq, st_req, st_rel;
    logic oreq, orel, nto, c_ld, c_st;
    logic mreq;
    ld_acq = ld[0]; ld_req = ld[1]; ld_rel = ld[2] | ld[3];
    st_acq = st[0]; st_req = st[1]; st_rel = st[2] | st[3];
    mreq = (m_owner == 1) ? ld_req : ((m_owner == 2) ? st_req : 1'b0);
    e = {(m_owner == 1), (m_owner == 2),
         ((m_pend_ld | ld_acq | ld_req) && (m_owner != 1)),
         ((m_pend_st | st_acq | st_req) && (m_owner != 2)),
         mreq, ((m_owner == 2) && st_req), m_last,
         ((m_owner != 0) || (m_drain > 0)), m_to};
    nto = 0;
    if (m_owner != 0) begin
      oreq = (m_owner == 1) ? ld_req : st_req;
      orel = (m_owner == 1) ? ld_rel : st_rel;
      if (m_owner == 1 && st_acq) m_pend_st = 1;
      if (m_owner == 2 && ld_acq) m_pend_ld = 1;
      m_idle = oreq ? 0 : m_idle + 1;
      if (MAX_IDLE > 0 && m_idle == MAX_IDLE) nto = 1;
      if (orel || nto) begin
        m_owner = 0; m_drain = DRAIN; m_idle = 0;
      end
    end else if (m_drain > 0) begin
      m_drain = m_drain - 1;
      m_pend_ld = m_pend_ld | ld_acq;
      m_pend_st = m_pend_st | st_acq;
    end else begin
      c_ld = m_pend_ld | ld_acq;
      c_st = m_pend_st | st_acq;
      m_pend_ld = c_ld;
      m_pend_st = c_st;
      if (c_ld && c_st) begin
        // both want it: the side not served last goes first
        if (m_last) begin m_owner = 1; m_pend_ld = 0; m_last = 0; end
        else        begin m_owner = 2; m_pend_st = 0; m_last = 1; end
        m_idle = 0;
      end else if (c_ld) begin
        m_owner = 1; m_pend_ld = 0; m_last = 0; m_idle = 0;
      end else if (c_st) begin
        m_owner = 2; m_pend_st = 0; m_last = 1; m_idle = 0;
      end
    end
    m_to = nto;
  endtask

  task automatic drive(input logic [3:0] ld, input logic [3:0] st);
    arb_if.I_Ld_Acq = ld[0]; arb_if.I_Ld_Req = ld[1];
    arb_if.I_Ld_Rls = ld[2]; arb_if.I_Ld_Trm = ld[3];
    arb_if.I_St_Acq = st[0]; arb_if.I_St_Req = st[1];
    arb_if.I_St_Rls = st[2]; arb_if.I_St_Trm = st[3];
  endtask

  task automatic step(input logic [3:0] ld, input logic [3:0] st);
    logic [8:0] e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(ld, st);
    model_step(ld, st, e);
    exp_q.push_back(e);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(NONE, NONE);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      drive(NONE, NONE);
      rst_n = 1'b0;
      model_reset();
      exp_q.push_back(9'b0);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] e;
    cycle++;
    act = {arb_if.O_Ld_Grant, arb_if.O_St_Grant, arb_if.O_Ld_Nack,
           arb_if.O_St_Nack, arb_if.O_Mem_Req, arb_if.O_Mem_We,
           arb_if.O_Sel, arb_if.O_Busy, arb_if.O_Timeout};
    if (arb_if.O_Timeout === 1'b1) to_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b expected %b (gld gst nld nst req we sel busy to)",
                 cycle, act, e);
      end
    end
  end

  initial begin
    int base;
    logic [3:0] ld, st;
    rst_n = 1'b0;
    drive(NONE, NONE);
    model_reset();
    reset_cycles(2);

    // lone load sequence
    step(ACQ, NONE);
    step(REQ, NONE); step(NONE, NONE); step(REQ, NONE); step(REQ, NONE);
    step(RLS, NONE);
    idle_steps(4);

    // reset asserted mid-grant, then a fresh store sequence
    step(ACQ, NONE);
    step(REQ, NONE);
    reset_cycles(3);
    step(NONE, NONE);
    step(NONE, ACQ);
    step(NONE, REQ); step(NONE, REQ);
    step(NONE, RLS);
    idle_steps(3);

    // simultaneous start right after reset: store goes first
    reset_cycles(1);
    step(ACQ, ACQ);
    step(REQ, REQ); step(REQ, NONE); step(NONE, REQ);
    step(REQ, RLS);
    step(REQ, NONE); step(NONE, NONE); step(REQ, NONE);
    step(REQ, NONE);
    step(RLS, NONE);
    idle_steps(3);

    // contention: store stalled while load owns, served after termination
    step(ACQ, NONE);
    step(REQ, NONE);
    step(NONE, ACQ);
    step(REQ, REQ);
    step(NONE, REQ);
    step(TRM, REQ);
    idle_steps(5);
    step(NONE, RLS | TRM);
    idle_steps(3);

    // watchdog: store owns the bank and goes silent
    @(negedge clk); #1;
    base = to_seen;
    step(NONE, ACQ);
    idle_steps(MAX_IDLE + 6);
    @(negedge clk); #1;
    checks++;
    if (to_seen - base != 1) begin
      errors++;
      $display("FAIL watchdog_pulses: got %0d expected 1", to_seen - base);
    end

    // final word forwarded with release while store starts a sequence
    step(ACQ, NONE);
    step(REQ, NONE);
    step(REQ | RLS, ACQ);
    idle_steps(5);
    step(NONE, RLS);
    idle_steps(3);

    // randomized controller activity
    for (int i = 0; i < 600; i++) begin
      ld = NONE; st = NONE;
      ld[0] = ($urandom_range(0, 9) == 0);
      ld[1] = ($urandom_range(0, 9) < 4);
      ld[2] = ($urandom_range(0, 11) == 0);
      ld[3] = ($urandom_range(0, 29) == 0);
      st[0] = ($urandom_range(0, 9) == 0);
      st[1] = ($urandom_range(0, 9) < 4);
      st[2] = ($urandom_range(0, 11) == 0);
      st[3] = ($urandom_range(0, 29) == 0);
      step(ld, st);
    end
    idle_steps(4);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
